// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Issues in-order word requests to instruction memory, queues the returned
// words with their PCs in a small circular FIFO, and flushes/restarts on a
// redirect from execute. Requests are credit-limited so that the queue can
// always absorb every response that is still in flight.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_raw,
    output logic [31:0] instr_pc
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   CREDIT  = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [31:0]      fetch_pc;
    logic [31:0]      resp_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [31:0]      data_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];

    logic [CNT_W:0]   in_use;
    logic             req_fire;
    logic             enq;
    logic             deq;
    logic [CNT_W-1:0] issue_inc;
    logic [CNT_W-1:0] resp_dec;
    logic [CNT_W-1:0] enq_inc;
    logic [CNT_W-1:0] deq_dec;
    logic [31:0]      redirect_base;
    logic [1:0]       unused_pc_bits;

    // Credit covers both queued words and words still owed by memory, so an
    // accepted request always has a queue slot waiting for its response.
    assign in_use         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !redirect && (in_use < CREDIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses owed to a flushed PC stream are discarded until drop hits 0.
    assign enq = imem_resp_valid && (drop == '0) && !redirect;

    // Decode handshake is meaningless in a redirect cycle: decode is flushed too.
    assign instr_valid = !reset && (count != '0);
    assign deq         = instr_valid && instr_ready && !redirect;
    assign instr_raw   = data_mem[head];
    assign instr_pc    = pc_mem[head];

    assign issue_inc = {{(CNT_W-1){1'b0}}, req_fire};
    assign resp_dec  = {{(CNT_W-1){1'b0}}, imem_resp_valid};
    assign enq_inc   = {{(CNT_W-1){1'b0}}, enq};
    assign deq_dec   = {{(CNT_W-1){1'b0}}, deq};

    // Redirect targets are word aligned; the low address bits are ignored.
    assign redirect_base  = {redirect_pc[31:2], 2'b00};
    assign unused_pc_bits = redirect_pc[1:0];

    // Control state: PCs, occupancy, in-flight and discard counters, pointers.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            head        <= '0;
            tail        <= '0;
        end else if (redirect) begin
            // Every request still owed (minus one answered right now) is stale.
            fetch_pc    <= redirect_base;
            resp_pc     <= redirect_base;
            count       <= '0;
            head        <= '0;
            tail        <= '0;
            outstanding <= outstanding - resp_dec;
            drop        <= outstanding - resp_dec;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (enq) begin
                resp_pc <= resp_pc + 32'd4;
                tail    <= tail + PTR_ONE;
            end
            if (deq) begin
                head <= head + PTR_ONE;
            end
            if (imem_resp_valid && (drop != '0)) begin
                drop <= drop - CNT_ONE;
            end
            outstanding <= outstanding + issue_inc - resp_dec;
            count       <= count + enq_inc - deq_dec;
        end
    end

    // Queue storage: each entry holds a fetched word and the PC it came from.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (enq) begin
            data_mem[tail] <= imem_resp_data;
            pc_mem[tail]   <= resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a latency-programmable
// in-order memory model and a scoreboard of expected PCs at the decode port.
module tb_fetch_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr_raw;
    logic [31:0] instr_pc;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sb[$];
    int          cyc      = 0;
    int          latency  = 1;
    int          accepted = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_raw       (instr_raw),
        .instr_pc        (instr_pc)
    );

    initial forever #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Instruction word stored at an address in the memory model.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a ^ 32'hA5C3_0000) + 32'h0000_1111;
    endfunction

    // Memory model: in-order responses exactly `latency` cycles after acceptance.
    initial begin
        pend_t p;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clock);
            if (reset) begin
                pend.delete();
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    p = pend.pop_front();
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = word_of(p.addr);
                end else begin
                    imem_resp_valid = 1'b0;
                    imem_resp_data  = 32'h0;
                end
                if (imem_req_valid && imem_req_ready) begin
                    pend.push_back('{imem_req_addr, cyc + latency});
                    accepted++;
                end
            end
        end
    end

    // Monitor: every decode handshake must match the next expected PC and word.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clock);
            if (!reset && !redirect && instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_instr: got pc %h, no instruction expected", instr_pc);
                end else begin
                    exp_pc = sb.pop_front();
                    compared++;
                    if (instr_pc !== exp_pc) begin
                        mismatched++;
                        $display("FAIL instr_pc: got %h, expected %h", instr_pc, exp_pc);
                    end
                    compared++;
                    if (instr_raw !== word_of(exp_pc)) begin
                        mismatched++;
                        $display("FAIL instr_raw: got %h, expected %h", instr_raw, word_of(exp_pc));
                    end
                end
            end
            if (!reset && int'(dut.count) > 2) begin
                mismatched++;
                $display("FAIL count_bound: got %0d, expected <= 2", dut.count);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic expect_pcs(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(base + 32'(4 * i));
        end
    endtask

    // Reset, configure, release; returns inside the first cycle with reset low.
    task automatic start_phase(input int lat, input logic ir, input logic rr);
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = ir;
        imem_req_ready = rr;
        latency        = lat;
        tick();
        tick();
        sb.delete();
        reset = 1'b0;
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (sb.size() == 0) begin
                break;
            end
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: got %0d pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        int base;

        // Reset state
        tick();
        tick();
        @(negedge clock);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_raw", instr_raw, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // Streaming from reset, L = 1, always ready
        start_phase(1, 1'b1, 1'b1);
        expect_pcs(32'h0, 8);
        @(negedge clock);
        check("a_req_valid0", 32'(imem_req_valid), 32'd1);
        check("a_req_addr0", imem_req_addr, 32'h0);
        check("a_instr_valid0", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clock);
        check("a_req_valid1", 32'(imem_req_valid), 32'd1);
        check("a_req_addr1", imem_req_addr, 32'h4);
        tick();
        @(negedge clock);
        check("a_first_valid", 32'(instr_valid), 32'd1);
        check("a_first_pc", instr_pc, 32'h0);
        wait_empty("a", 60);
        instr_ready = 1'b0;

        // Decode stalled for 5 cycles
        start_phase(1, 1'b0, 1'b1);
        base = accepted;
        tick();
        tick();
        tick();
        @(negedge clock);
        check("b_instr_valid", 32'(instr_valid), 32'd1);
        check("b_head_pc", instr_pc, 32'h0);
        check("b_head_raw3", instr_raw, word_of(32'h0));
        check("b_req_valid3", 32'(imem_req_valid), 32'd0);
        tick();
        @(negedge clock);
        check("b_head_raw4", instr_raw, word_of(32'h0));
        check("b_req_valid4", 32'(imem_req_valid), 32'd0);
        check("b_queue_count", 32'(dut.count), 32'd2);
        tick();
        check("b_req_issued", 32'(accepted - base), 32'd2);
        expect_pcs(32'h0, 3);
        instr_ready = 1'b1;
        wait_empty("b", 60);
        instr_ready = 1'b0;

        // Memory not ready for 3 cycles
        start_phase(1, 1'b1, 1'b0);
        expect_pcs(32'h0, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("c_req_valid_held", 32'(imem_req_valid), 32'd1);
            check("c_req_addr_held", imem_req_addr, 32'h0);
            check("c_instr_valid", 32'(instr_valid), 32'd0);
            tick();
        end
        imem_req_ready = 1'b1;
        wait_empty("c", 60);
        instr_ready = 1'b0;

        // L = 3, redirect to 0x100 with two requests in flight
        start_phase(3, 1'b1, 1'b1);
        expect_pcs(32'h100, 3);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        @(negedge clock);
        check("d_outstanding", 32'(dut.outstanding), 32'd2);
        check("d_req_valid_redirect", 32'(imem_req_valid), 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clock);
        check("d_req_addr", imem_req_addr, 32'h100);
        check("d_instr_valid", 32'(instr_valid), 32'd0);
        check("d_drop", 32'(dut.drop), 32'd2);
        wait_empty("d", 80);
        instr_ready = 1'b0;

        // L = 2, redirect to 0x203 in the cycle the first response arrives
        start_phase(2, 1'b1, 1'b1);
        expect_pcs(32'h200, 3);
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        tick();
        redirect = 1'b0;
        @(negedge clock);
        check("e_drop", 32'(dut.drop), 32'd1);
        check("e_outstanding", 32'(dut.outstanding), 32'd1);
        check("e_req_valid", 32'(imem_req_valid), 32'd1);
        check("e_req_addr", imem_req_addr, 32'h200);
        wait_empty("e", 80);
        instr_ready = 1'b0;

        // Reset while the queue is full
        start_phase(1, 1'b0, 1'b1);
        tick();
        tick();
        tick();
        tick();
        @(negedge clock);
        check("f_full_valid", 32'(instr_valid), 32'd1);
        check("f_full_count", 32'(dut.count), 32'd2);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("f_rst_instr_valid", 32'(instr_valid), 32'd0);
        check("f_rst_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        @(negedge clock);
        check("f_rst1_instr_valid", 32'(instr_valid), 32'd0);
        check("f_rst1_req_valid", 32'(imem_req_valid), 32'd0);
        check("f_rst1_count", 32'(dut.count), 32'd0);
        tick();
        reset = 1'b0;
        expect_pcs(32'h0, 2);
        @(negedge clock);
        check("f_req_valid", 32'(imem_req_valid), 32'd1);
        check("f_req_addr", imem_req_addr, 32'h0);
        tick();
        instr_ready = 1'b1;
        wait_empty("f", 60);
        instr_ready = 1'b0;

        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
